// File: rtl/micro_tiles_pkg.sv
// Shared constants and helpers for the micro tile container: tile select
// codes, LFSR seed/taps and the small arithmetic helpers used by the bank.
package micro_tiles_pkg;

    localparam int TILE_W = 8;

    localparam logic [1:0] TILE_CNT   = 2'd0;
    localparam logic [1:0] TILE_SHIFT = 2'd1;
    localparam logic [1:0] TILE_MUL   = 2'd2;
    localparam logic [1:0] TILE_LFSR  = 2'd3;

    localparam logic [TILE_W-1:0] LFSR_SEED = 8'h01;

    // Taps for x^8+x^6+x^5+x^4+1 in a left-shifting Fibonacci register:
    // feedback is the XOR of bits 7, 5, 4 and 3.
    localparam logic [TILE_W-1:0] LFSR_TAPS = 8'b1011_1000;

    function automatic logic [TILE_W-1:0] lfsr_next(input logic [TILE_W-1:0] state);
        return {state[TILE_W-2:0], ^(state & LFSR_TAPS)};
    endfunction

    // 3x3 unsigned product, widened before multiplying so no bits are lost.
    function automatic logic [5:0] mul3x3(input logic [2:0] a, input logic [2:0] b);
        logic [5:0] wide_a;
        logic [5:0] wide_b;
        wide_a = {3'b000, a};
        wide_b = {3'b000, b};
        return wide_a * wide_b;
    endfunction

endpackage

// File: rtl/micro_tile_bank.sv
// Holds the four concurrently running micro tiles. Every tile updates each
// cycle from the shared data bus; which one is visible is decided by the top.
module micro_tile_bank
    import micro_tiles_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [5:0]        data,
    output logic [TILE_W-1:0] cnt_q,
    output logic [TILE_W-1:0] shift_q,
    output logic [TILE_W-1:0] mul_q,
    output logic [TILE_W-1:0] lfsr_q
);

    logic step;
    logic dir_down;
    logic shift_bit;

    assign step      = ena & data[0];
    assign dir_down  = data[1];
    assign shift_bit = data[1];

    // Tile 0: up/down counter, wraps naturally modulo 256.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (step) begin
            if (dir_down) begin
                cnt_q <= cnt_q - 8'd1;
            end else begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    // Tile 1: serial-in shift register, new bit enters at the LSB.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_q <= '0;
        end else if (step) begin
            shift_q <= {shift_q[TILE_W-2:0], shift_bit};
        end
    end

    // Tile 2: registered 3x3 multiplier; runs whenever enabled, step not needed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mul_q <= '0;
        end else if (ena) begin
            mul_q <= {2'b00, mul3x3(data[2:0], data[5:3])};
        end
    end

    // Tile 3: maximal-length LFSR; seed is nonzero so the all-zero lockup
    // state is unreachable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else if (step) begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

endmodule

// File: rtl/micro_tiles_container.sv
// Tiny Tapeout wrapper hosting four micro tiles. ui_in[7:6] picks which
// tile drives uo_out; bidirectional pins are left as inputs and ignored.
module micro_tiles_container
    import micro_tiles_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [TILE_W-1:0] cnt_q;
    logic [TILE_W-1:0] shift_q;
    logic [TILE_W-1:0] mul_q;
    logic [TILE_W-1:0] lfsr_q;
    logic [1:0]        sel;
    logic              unused_uio;

    assign sel        = ui_in[7:6];
    assign unused_uio = ^uio_in;

    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

    micro_tile_bank u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .data    (ui_in[5:0]),
        .cnt_q   (cnt_q),
        .shift_q (shift_q),
        .mul_q   (mul_q),
        .lfsr_q  (lfsr_q)
    );

    // Output steering is purely combinational so a select change shows
    // up in the same cycle.
    always_comb begin
        uo_out = cnt_q;
        case (sel)
            TILE_CNT:   uo_out = cnt_q;
            TILE_SHIFT: uo_out = shift_q;
            TILE_MUL:   uo_out = mul_q;
            TILE_LFSR:  uo_out = lfsr_q;
            default:    uo_out = cnt_q;
        endcase
    end

endmodule

// File: tb/tb_micro_tiles_container.sv
// Bench for micro_tiles_container: directed scenarios followed by random
// traffic, all checked against an arithmetic model of the four tiles.
module tb_micro_tiles_container;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int nvec;
    int nerr;

    int m_cnt;
    int m_sr;
    int m_prod;
    int m_lfsr;

    micro_tiles_container dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: applies the tile rules to the inputs present at the edge.
    task automatic model_edge();
        int a;
        int b;
        int fb;
        if (!rst_n) begin
            m_cnt  = 0;
            m_sr   = 0;
            m_prod = 0;
            m_lfsr = 1;
        end else if (ena) begin
            a = int'(ui_in[2:0]);
            b = int'(ui_in[5:3]);
            m_prod = a * b;
            if (ui_in[0]) begin
                if (ui_in[1]) m_cnt = (m_cnt + 255) % 256;
                else          m_cnt = (m_cnt + 1) % 256;
                m_sr = (m_sr * 2 + int'(ui_in[1])) % 256;
                fb = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1;
                m_lfsr = (m_lfsr * 2 + fb) % 256;
            end
        end
    endtask

    function automatic logic [7:0] exp_out(input logic [1:0] s);
        case (s)
            2'd0:    return 8'(m_cnt);
            2'd1:    return 8'(m_sr);
            2'd2:    return 8'(m_prod);
            default: return 8'(m_lfsr);
        endcase
    endfunction

    task automatic tick();
        uio_in = 8'($urandom);
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag);
        logic [7:0] want;
        want = exp_out(ui_in[7:6]);
        nvec++;
        assert (uo_out === want) else begin
            nerr++;
            $error("FAIL %s: uo_out=%h expected %h (sel=%0d)", tag, uo_out, want, ui_in[7:6]);
        end
    endtask

    task automatic check_ties(input string tag);
        nvec++;
        assert ({uio_out, uio_oe} === 16'h0000) else begin
            nerr++;
            $error("FAIL %s: uio_out=%h uio_oe=%h expected 00 00", tag, uio_out, uio_oe);
        end
    endtask

    task automatic check_const(input string tag, input logic [7:0] want);
        nvec++;
        assert (uo_out === want) else begin
            nerr++;
            $error("FAIL %s: uo_out=%h expected %h", tag, uo_out, want);
        end
    endtask

    task automatic set_sel(input logic [1:0] s);
        ui_in[7:6] = s;
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        for (int i = 0; i < cycles; i++) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        logic saw_zero;
        nvec  = 0;
        nerr  = 0;
        m_cnt = 0; m_sr = 0; m_prod = 0; m_lfsr = 1;
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h3F;
        uio_in = 8'h00;
        #2;

        // Reset: two edges low with ena=1 and stepping inputs.
        do_reset(2);
        ui_in = 8'h00;
        for (int s = 0; s < 4; s++) begin
            set_sel(2'(s));
            check($sformatf("reset_sel%0d", s));
        end
        set_sel(2'd3);
        check_const("reset_lfsr_seed", 8'h01);
        check_ties("reset_ties");

        // Counter: 3 up, 4 down through the wrap, then frozen by ena=0.
        do_reset(1);
        ui_in = {2'd0, 6'b000001};
        for (int i = 0; i < 3; i++) tick();
        check("cnt_up3");
        ui_in[1:0] = 2'b11;
        for (int i = 0; i < 4; i++) tick();
        check("cnt_wrap");
        check_const("cnt_wrap_ff", 8'hFF);
        ena = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("cnt_hold_ena0");
        for (int s = 0; s < 4; s++) begin
            set_sel(2'(s));
            check($sformatf("hold_sel%0d", s));
        end
        ena = 1'b1;

        // Shift: bits 1,0,1,1 then no-step cycles.
        do_reset(1);
        ui_in = {2'd1, 6'b000000};
        for (int i = 0; i < 4; i++) begin
            ui_in[1] = (i == 1) ? 1'b0 : 1'b1;
            ui_in[0] = 1'b1;
            tick();
        end
        check("shift_1011");
        check_const("shift_0b", 8'h0B);
        ui_in[1:0] = 2'b10;
        for (int i = 0; i < 3; i++) tick();
        check("shift_hold");

        // Multiplier: 7*7 then 5*0, one cycle latency each.
        ui_in = {2'd2, 3'd7, 3'd7};
        tick();
        check("mul_7x7");
        check_const("mul_49", 8'h31);
        ui_in = {2'd2, 3'd5, 3'd0};
        tick();
        check("mul_5x0");

        // LFSR: full period from the seed, never zero.
        do_reset(1);
        ui_in = {2'd3, 6'b000001};
        saw_zero = 1'b0;
        for (int i = 0; i < 255; i++) begin
            tick();
            if (uo_out == 8'h00) saw_zero = 1'b1;
            if (i < 6 || i == 254) check($sformatf("lfsr_step%0d", i + 1));
        end
        check_const("lfsr_period", 8'h01);
        nvec++;
        assert (saw_zero === 1'b0) else begin
            nerr++;
            $error("FAIL lfsr_zero: saw_zero=%b expected 0", saw_zero);
        end

        // Concurrency, same-cycle select and mid-run reset.
        do_reset(1);
        ui_in = {2'd0, 6'b000011};
        tick();
        tick();
        set_sel(2'd0); check("conc_cnt");
        set_sel(2'd1); check("conc_shift");
        set_sel(2'd3); check("conc_lfsr");
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int s = 0; s < 4; s++) begin
            set_sel(2'(s));
            check($sformatf("midreset_sel%0d", s));
        end

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 49) != 0);
            ena   = ($urandom_range(0, 4) != 0);
            ui_in = 8'($urandom);
            tick();
            check("rand_post_edge");
            set_sel(2'($urandom));
            check("rand_sel_change");
            if (i % 50 == 0) check_ties("rand_ties");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
